// File: rtl/apb_fifo_reader.sv
// rtl/apb_fifo_reader.sv - pops packed commands from the bridge FIFO and runs each as one APB transfer
// Response is held on a valid/ready port until accepted; ACCESS is bounded by an optional timeout.
module apb_fifo_reader #(
  parameter int ADDRW    = 8,
  parameter int DATAW    = 32,
  parameter int DATASIZE = 41,
  parameter int TIMEOUT  = 15
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                rempty,
  output logic                rinc,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDRW-1:0]    paddr,
  output logic [DATAW-1:0]    pwdata,
  input  logic [DATAW-1:0]    prdata,
  input  logic                pready,
  input  logic                pslverr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic                rsp_err,
  output logic [DATAW-1:0]    rsp_rdata,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDRW-1:0]   paddr_q, paddr_d;
  logic [DATAW-1:0]   pwdata_q, pwdata_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_write_q, rsp_write_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DATAW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic               busy_q, busy_d;
  logic               rinc_c;
  logic               timeout_hit;

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rinc_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The pop is suppressed during reset so an entry is never lost while the FSM is forced idle.
        if (!rempty && !rrst) begin
          rinc_c  = 1'b1;
        end
        if (!rempty) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pwrite_d = rdata[DATASIZE-1];
        paddr_d  = rdata[DATAW +: ADDRW];
        pwdata_d = rdata[DATAW-1:0];
        state_d  = S_SETUP;
      end
      S_SETUP: begin
        cnt_d   = 8'd0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          rsp_write_d = pwrite_q;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (pwrite_q || pslverr) ? '0 : prdata;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          rsp_write_d = pwrite_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_RESP;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus and handshake flags are decoded from the next state so they leave a flop directly.
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cnt_q       <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign rinc      = rinc_c;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;

endmodule
